// File: rtl/predictor_update_ctrl_pkg.sv
// Shared definitions for the branch predictor pattern table: controller states,
// 2-bit counter encodings and the counter update function.
`timescale 1ns/1ps
package predictor_update_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrlState_e;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;
  localparam logic [1:0] CTR_INIT      = CTR_WEAK_NT;

  // Counter transition used by both the predictor and the update path.
  function automatic logic [1:0] nextCounter(input logic [1:0] cur, input logic isTaken);
    logic [1:0] nxt;
    case (cur)
      CTR_STRONG_NT: nxt = isTaken ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   nxt = isTaken ? CTR_STRONG_T : CTR_STRONG_NT;
      CTR_WEAK_T:    nxt = isTaken ? CTR_STRONG_T : CTR_WEAK_T;
      default:       nxt = isTaken ? CTR_STRONG_T : CTR_WEAK_T;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/update_fifo.sv
// Synchronous FIFO for queued predictor updates; DEPTH must be a power of two.
`timescale 1ns/1ps
module update_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clockIn,
  input  logic             resetIn,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign popData = mem[headPtr];

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + PTR_W'(1);
      if (doPop)  headPtr <= headPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clockIn) begin
    if (doPush) mem[tailPtr] <= pushData;
  end

endmodule

// File: rtl/predictor_update_ctrl.sv
// Pattern-table update controller: sweeps the table to weakly-not-taken after reset,
// then applies queued branch outcomes one per cycle through a read-modify-write.
`timescale 1ns/1ps
module predictor_update_ctrl
  import predictor_update_ctrl_pkg::*;
#(
  parameter int unsigned LOCAL_WIDTH = 12,
  parameter int unsigned QUEUE_DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic                   updateValid,
  input  logic [31:0]            updateInstr,
  input  logic                   taken,
  input  logic [1:0]             tableRdData,
  output logic [LOCAL_WIDTH-1:0] tableRdIdx,
  output logic                   tableWrEn,
  output logic [LOCAL_WIDTH-1:0] tableWrIdx,
  output logic [1:0]             tableWrData,
  output logic                   initDone,
  output logic [CNT_W-1:0]       queueCount,
  output logic [7:0]             dropCount
);

  localparam int unsigned ENTRY_W = LOCAL_WIDTH + 1;

  ctrlState_e             state;
  logic [LOCAL_WIDTH-1:0] sweepIdx;
  logic [LOCAL_WIDTH-1:0] updateIdx;
  logic [LOCAL_WIDTH-1:0] headIdx;
  logic                   headTaken;
  logic [ENTRY_W-1:0]     headEntry;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   unusedInstrBits;

  // Instructions are word aligned, so the low two bits carry no index information.
  assign updateIdx       = updateInstr[LOCAL_WIDTH+1:2];
  assign unusedInstrBits = ^{updateInstr[31:LOCAL_WIDTH+2], updateInstr[1:0]};

  assign headIdx   = headEntry[ENTRY_W-1:1];
  assign headTaken = headEntry[0];

  assign pop  = (state == RUN) && !empty;
  assign push = updateValid && (!full || pop);

  update_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) uFifo (
    .clockIn  (clockIn),
    .resetIn  (resetIn),
    .push     (push),
    .pushData ({updateIdx, taken}),
    .pop      (pop),
    .popData  (headEntry),
    .full     (full),
    .empty    (empty),
    .count    (queueCount)
  );

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state     <= INIT;
      sweepIdx  <= '0;
      initDone  <= 1'b0;
      dropCount <= '0;
    end else begin
      case (state)
        INIT: begin
          sweepIdx <= sweepIdx + LOCAL_WIDTH'(1);
          if (sweepIdx == '1) begin
            state    <= RUN;
            initDone <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
      if (updateValid && !push && (dropCount != 8'hFF)) dropCount <= dropCount + 8'd1;
    end
  end

  // Sweep owns the write port during INIT; afterwards the queue head does.
  always_comb begin
    tableRdIdx  = headIdx;
    tableWrEn   = 1'b0;
    tableWrIdx  = headIdx;
    tableWrData = nextCounter(tableRdData, headTaken);
    if (state == INIT) begin
      tableWrEn   = 1'b1;
      tableWrIdx  = sweepIdx;
      tableWrData = CTR_INIT;
    end else if (pop) begin
      tableWrEn = 1'b1;
    end
  end

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Directed bench for predictor_update_ctrl: small table instance for sweep/queue/RMW
// behaviour, larger-table instance for drop-counter saturation during a long INIT.
`timescale 1ns/1ps
module tb_predictor_update_ctrl;

  logic clockIn;
  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  // Instance A: LOCAL_WIDTH=4, QUEUE_DEPTH=4
  logic       resetIn, updateValid, taken;
  logic [31:0] updateInstr;
  logic [1:0] tableRdData;
  logic [3:0] tableRdIdx, tableWrIdx;
  logic       tableWrEn, initDone;
  logic [1:0] tableWrData;
  logic [2:0] queueCount;
  logic [7:0] dropCount;

  // Instance B: LOCAL_WIDTH=9, QUEUE_DEPTH=4
  logic       resetB, validB, takenB;
  logic [31:0] instrB;
  logic [1:0] rdDataB;
  logic [8:0] rdIdxB, wrIdxB;
  logic       wrEnB, initDoneB;
  logic [1:0] wrDataB;
  logic [2:0] qCountB;
  logic [7:0] dropB;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  predictor_update_ctrl #(.LOCAL_WIDTH(4), .QUEUE_DEPTH(4)) dutA (
    .clockIn(clockIn), .resetIn(resetIn), .updateValid(updateValid),
    .updateInstr(updateInstr), .taken(taken), .tableRdData(tableRdData),
    .tableRdIdx(tableRdIdx), .tableWrEn(tableWrEn), .tableWrIdx(tableWrIdx),
    .tableWrData(tableWrData), .initDone(initDone), .queueCount(queueCount),
    .dropCount(dropCount)
  );

  predictor_update_ctrl #(.LOCAL_WIDTH(9), .QUEUE_DEPTH(4)) dutB (
    .clockIn(clockIn), .resetIn(resetB), .updateValid(validB),
    .updateInstr(instrB), .taken(takenB), .tableRdData(rdDataB),
    .tableRdIdx(rdIdxB), .tableWrEn(wrEnB), .tableWrIdx(wrIdxB),
    .tableWrData(wrDataB), .initDone(initDoneB), .queueCount(qCountB),
    .dropCount(dropB)
  );

  // Pattern table storage seen by instance A: combinational read, write at the edge.
  logic [1:0] tbTable [16];
  always @(posedge clockIn) if (tableWrEn) tbTable[tableWrIdx] <= tableWrData;
  assign tableRdData = tbTable[tableRdIdx];
  assign rdDataB = 2'b01;

  function automatic logic [31:0] mkInstr(input int idx);
    return (32'hDEADBEC3 & ~32'h0000003C) | (32'(idx) << 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input logic t);
    updateValid = v;
    updateInstr = mkInstr(idx);
    taken       = t;
  endtask

  task automatic checkWrite(input string tag, input logic en, input int idx, input logic [1:0] data);
    check({tag, "_en"}, 32'(tableWrEn), 32'(en));
    check({tag, "_idx"}, 32'(tableWrIdx), 32'(idx));
    check({tag, "_data"}, 32'(tableWrData), 32'(data));
  endtask

  int         rmwIdx   [7] = '{3, 3, 3, 3, 3, 6, 6};
  logic       rmwTaken [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] rmwExp   [7] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
  logic       initTaken [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int         drainIdx [4] = '{6, 7, 8, 11};
  logic [1:0] drainData[4] = '{2'b00, 2'b11, 2'b11, 2'b11};
  int         drainCnt [4] = '{4, 3, 2, 1};

  initial begin
    resetIn = 1'b1; resetB = 1'b1; validB = 1'b0; takenB = 1'b0; instrB = '0;
    drive(1'b0, 0, 1'b0);
    tick();
    resetIn = 1'b0;
    #1;
    check("rst_initDone", 32'(initDone), 0);
    check("rst_queueCount", 32'(queueCount), 0);
    check("rst_dropCount", 32'(dropCount), 0);

    // Sweep with six updates arriving while the queue cannot drain.
    for (int i = 0; i < 16; i++) begin
      if (i < 6) drive(1'b1, 5 + i, initTaken[i]);
      else       drive(1'b0, 0, 1'b0);
      #1;
      checkWrite("sweep", 1'b1, i, 2'b01);
      check("sweep_initDone", 32'(initDone), 0);
      if (i == 6) begin
        check("init_queueCount", 32'(queueCount), 4);
        check("init_dropCount", 32'(dropCount), 2);
      end
      tick();
    end

    // First RUN cycle: queue full, dequeue and enqueue together.
    drive(1'b1, 11, 1'b1);
    #1;
    check("run_initDone", 32'(initDone), 1);
    check("run_rdIdx", 32'(tableRdIdx), 5);
    checkWrite("drain0", 1'b1, 5, 2'b11);
    check("drain0_count", 32'(queueCount), 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 0, 1'b0);
      #1;
      checkWrite("drain", 1'b1, drainIdx[k], drainData[k]);
      check("drain_count", 32'(queueCount), 32'(drainCnt[k]));
      check("drain_rdIdx", 32'(tableRdIdx), 32'(drainIdx[k]));
      check("drain_dropCount", 32'(dropCount), 2);
      tick();
    end
    #1;
    check("empty_wrEn", 32'(tableWrEn), 0);
    check("empty_count", 32'(queueCount), 0);

    // Back-to-back read-modify-write on the same index, one-cycle latency.
    for (int k = 0; k < 8; k++) begin
      if (k < 7) drive(1'b1, rmwIdx[k], rmwTaken[k]);
      else       drive(1'b0, 0, 1'b0);
      #1;
      if (k == 0) check("nobypass_wrEn", 32'(tableWrEn), 0);
      else begin
        checkWrite("rmw", 1'b1, rmwIdx[k-1], rmwExp[k-1]);
        check("rmw_count", 32'(queueCount), 1);
      end
      tick();
    end
    #1;
    check("rmw_idle_wrEn", 32'(tableWrEn), 0);

    // Reset in RUN restarts the sweep.
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    #1;
    checkWrite("runrst", 1'b1, 0, 2'b01);
    check("runrst_initDone", 32'(initDone), 0);

    // Reset at sweep index 9 with queued and dropped updates.
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive(1'b1, i + 1, 1'b1);
      else       drive(1'b0, 0, 1'b0);
      #1;
      tick();
    end
    #1;
    check("mid_idx9", 32'(tableWrIdx), 9);
    check("mid_queueCount", 32'(queueCount), 4);
    check("mid_dropCount", 32'(dropCount), 1);
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    #1;
    checkWrite("midrst", 1'b1, 0, 2'b01);
    check("midrst_queueCount", 32'(queueCount), 0);
    check("midrst_dropCount", 32'(dropCount), 0);
    check("midrst_initDone", 32'(initDone), 0);
    tick();
    check("midrst_next_idx", 32'(tableWrIdx), 1);

    // Drop counter saturation on the large-table instance.
    resetB = 1'b1;
    tick();
    resetB = 1'b0;
    for (int i = 0; i < 300; i++) begin
      validB = 1'b1;
      takenB = 1'(i);
      instrB = 32'(i) << 2;
      tick();
      if (i == 9)   check("sat_drop10", 32'(dropB), 6);
      if (i == 258) check("sat_drop259", 32'(dropB), 255);
    end
    validB = 1'b0;
    #1;
    check("sat_drop300", 32'(dropB), 255);
    check("sat_queueCount", 32'(qCountB), 4);
    check("sat_initDone", 32'(initDoneB), 0);
    check("sat_wrIdx", 32'(wrIdxB), 300);
    check("sat_wrEn", 32'(wrEnB), 1);
    check("sat_wrData", 32'(wrDataB), 1);
    check("sat_rdIdx", 32'(rdIdxB), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/predictor_update_ctrl.md
PREDICTOR_UPDATE_CTRL -- requirements
Module: predictor_update_ctrl

Interface
REQ-001 SHALL have parameter LOCAL_WIDTH, default 12, meaning log2 of pattern-table entries.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, meaning update-queue entries (power of two, >=2).
REQ-003 clockIn  input  1  single clock; all state changes on its rising edge.
REQ-004 resetIn  input  1  reset, synchronous and active-high.
REQ-005 updateValid  input  1  ROB commits a resolved conditional branch this cycle.
REQ-006 updateInstr  input  32  address of that branch.
REQ-007 taken  input  1  resolved direction of that branch.
REQ-008 tableRdData  input  2  current counter at tableRdIdx (combinational table read).
REQ-009 tableRdIdx  output  LOCAL_WIDTH  index to read for the head update.
REQ-010 tableWrEn  output  1  write strobe to the pattern table.
REQ-011 tableWrIdx  output  LOCAL_WIDTH  write index.
REQ-012 tableWrData  output  2  write value.
REQ-013 initDone  output  1  table valid; fetch SHALL treat the prediction as not-taken while low.
REQ-014 queueCount  output  log2(QUEUE_DEPTH)+1  occupied queue entries.
REQ-015 dropCount  output  8  saturating count of discarded updates.

Function
REQ-016 States: INIT, RUN. INIT is entered on reset; RUN is entered after the last INIT write; RUN has no exit except reset.
REQ-017 INIT: a sweep counter runs 0..2^LOCAL_WIDTH-1, one write per cycle, tableWrEn=1, tableWrIdx=counter, tableWrData=2'b01. INIT lasts exactly 2^LOCAL_WIDTH cycles.
REQ-018 initDone SHALL rise in the cycle after the final sweep write and stay high until reset.
REQ-019 Index mapping: idx = updateInstr[LOCAL_WIDTH+1:2].
REQ-020 Enqueue: on updateValid with queue not full, or full with a dequeue this cycle, {idx, taken} is written at tail, in both states.
REQ-021 Drop: on updateValid with queue full and no dequeue, the update is discarded and dropCount increments, saturating at 255.
REQ-022 Dequeue: in RUN with the queue non-empty, the head is consumed every cycle. tableRdIdx=head idx, tableWrEn=1, tableWrIdx=head idx, and tableWrData=next(tableRdData, head taken), all in the same cycle.
REQ-023 next(): 00->T?01:00; 01->T?11:00; 10->T?11:10; 11->T?11:10.
REQ-024 Latency: an update accepted at edge N is written at the earliest in the cycle after N. There is no bypass from the input to the write port.
REQ-025 In RUN with the queue empty, tableWrEn=0. tableRdIdx SHALL equal the head index whenever the queue is non-empty.
REQ-026 Back-to-back updates to the same idx SHALL each see the previous write, because the read is combinational and the table is written at the edge.
REQ-027 Simultaneous enqueue and dequeue SHALL leave queueCount unchanged, and head and tail pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-028 In INIT no dequeue occurs, so at most QUEUE_DEPTH updates survive INIT and the rest are dropped.

Reset
REQ-029 With resetIn high at an edge: state=INIT, sweep counter=0, queue empty, pointers=0, dropCount=0.
REQ-030 Output values in the cycle after reset: initDone=0, queueCount=0, dropCount=0, tableWrEn=1, tableWrIdx=0, tableWrData=2'b01.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the sweep at index 0 and discard all queued updates.

Structure
REQ-032 The shared package SHALL hold: the state enum (INIT, RUN), the counter-encoding constants (2'b00..2'b11 and init value 2'b01), and the next() function, so the predictor and this block share one definition.
REQ-033 One sub-module SHALL be used: update_fifo, a parameterised synchronous FIFO with push, pop, full, empty and count.

Verification
REQ-034 LOCAL_WIDTH=4, reset for 1 cycle -> 16 writes of 01 to idx 0..15 on consecutive cycles, then initDone=1 on cycle 17.
REQ-035 During INIT, 6 updates with QUEUE_DEPTH=4 -> queueCount=4 and dropCount=2. After initDone, 4 writes occur in order on consecutive cycles.
REQ-036 RUN, tableRdData=01, update idx 3 taken -> the next cycle writes idx 3 data 11. A second taken to idx 3 (read 11) -> write 11.
REQ-037 RUN, queue full, updateValid in the same cycle as a dequeue -> accepted, queueCount stays 4, dropCount unchanged.
REQ-038 Reset asserted at sweep index 9 -> the next write is idx 0, the queue is empty, and dropCount=0.
REQ-039 300 updates while the queue is held full during INIT -> dropCount saturates at 255.
